// File: rtl/uart_cmd_initiator_if.sv
// Signal bundle between the UART command initiator (master) and its host / UART peers (slave).
// Request: a command transfers on a clock edge where req_valid && req_ready; tx_start, rx_valid and rsp_valid are single-cycle strobes.
interface uart_cmd_initiator_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;

  modport master (
    input  req_valid, req_cmd, tx_busy, rx_valid, rx_data,
    output req_ready, tx_start, tx_data, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_cmd, tx_busy, rx_valid, rx_data,
    input  req_ready, tx_start, tx_data, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/uart_cmd_initiator.sv
// Single-outstanding UART command initiator: send one byte, wait for a one-byte reply or time out.
// Optional bounded resend on timeout is built when UART_CMD_INIT_RETRY_EN is defined.
module uart_cmd_initiator #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRY      = 2,
  parameter int TO_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  uart_cmd_initiator_if.master bus,
  output logic       busy,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAIT_TX  = 3'd2,
    S_WAIT_RSP = 3'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          st;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_inc;
  logic            seen_busy;
  logic            tx_done;
  logic            timeout_hit;
  logic            retry_ok;

`ifdef UART_CMD_INIT_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;
  assign retry_ok = (retry_cnt < RW'(MAX_RETRY));
`else
  assign retry_ok = 1'b0;
`endif

  // Saturating increment: the counter must never wrap back into the live range.
  assign to_inc  = (to_cnt == {TO_W{1'b1}}) ? to_cnt : to_cnt + 1'b1;
  assign tx_done = seen_busy && !bus.tx_busy;

  // A reply or transmitter completion on the terminal cycle beats the timeout.
  assign timeout_hit = (to_cnt == TO_LAST) &&
                       (((st == S_WAIT_TX) && !tx_done) ||
                        ((st == S_WAIT_RSP) && !bus.rx_valid));

  assign state         = st;
  assign busy          = (st != S_IDLE);
  assign bus.req_ready = (st == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= S_IDLE;
      to_cnt        <= '0;
      seen_busy     <= 1'b0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= 8'h00;
      bus.rsp_err   <= 1'b0;
`ifdef UART_CMD_INIT_RETRY_EN
      retry_cnt     <= '0;
`endif
    end else begin
      bus.tx_start  <= 1'b0;
      bus.rsp_valid <= 1'b0;
      case (st)
        S_IDLE: begin
          if (bus.req_valid) begin
            bus.tx_data <= bus.req_cmd;
`ifdef UART_CMD_INIT_RETRY_EN
            retry_cnt   <= '0;
`endif
            st          <= S_SEND;
          end
        end
        S_SEND: begin
          seen_busy <= 1'b0;
          if (!bus.tx_busy) begin
            bus.tx_start <= 1'b1;
            to_cnt       <= '0;
            st           <= S_WAIT_TX;
          end
        end
        S_WAIT_TX: begin
          if (bus.tx_busy) seen_busy <= 1'b1;
          if (tx_done) begin
            to_cnt <= '0;
            st     <= S_WAIT_RSP;
          end else begin
            to_cnt <= to_inc;
          end
        end
        S_WAIT_RSP: begin
          to_cnt <= to_inc;
          if (bus.rx_valid) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.rx_data;
            bus.rsp_err   <= 1'b0;
            st            <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase

      // Timeout overrides the per-state next-state chosen above.
      if (timeout_hit) begin
        if (retry_ok) begin
`ifdef UART_CMD_INIT_RETRY_EN
          retry_cnt <= retry_cnt + 1'b1;
`endif
          st        <= S_SEND;
        end else begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b1;
          bus.rsp_data  <= 8'h00;
          st            <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Self-checking bench for uart_cmd_initiator with a short timeout (50 cycles) and MAX_RETRY = 2.
module tb_uart_cmd_initiator;

  localparam int TO_CYC = 50;
`ifdef UART_CMD_INIT_RETRY_EN
  localparam int EXP_ATTEMPTS = 3;
`else
  localparam int EXP_ATTEMPTS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic [2:0] state;

  uart_cmd_initiator_if bus ();

  uart_cmd_initiator #(
    .TIMEOUT_CYCLES(TO_CYC),
    .MAX_RETRY     (2),
    .TO_W          (6)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.master),
    .busy (busy),
    .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [8:0] exp_q[$];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_tx     = 0;
  logic [7:0] cur_cmd  = 8'h00;
  logic       prev_rsp = 1'b0;

  // transmitter model controls
  int   busy_len  = 10;
  logic hold_busy = 1'b0;
  int   model_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transmitter model: goes busy for busy_len cycles after each tx_start.
  always @(negedge clk) begin
    if (model_cnt > 0) model_cnt = model_cnt - 1;
    if (rst && bus.tx_start && busy_len > 0) model_cnt = busy_len;
    bus.tx_busy = (model_cnt > 0) || hold_busy;
  end

  // Output monitor: tx launches and responses against the expected queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      if (bus.tx_start) begin
        n_tx = n_tx + 1;
        check("tx_data", {24'd0, bus.tx_data}, {24'd0, cur_cmd});
      end
      if (bus.rsp_valid) begin
        if (prev_rsp) check("rsp_back_to_back", 1, 0);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {23'd0, bus.rsp_err, bus.rsp_data}, 32'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("rsp", {23'd0, bus.rsp_err, bus.rsp_data}, {23'd0, e});
        end
      end
    end
    prev_rsp = bus.rsp_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [7:0] c);
    int i;
    for (i = 0; i < 500 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) check("req_ready_wait", 0, 1);
    cur_cmd       = c;
    bus.req_cmd   = c;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    bus.rx_data  = d;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int i;
    for (i = 0; i < budget && state != s; i++) @(negedge clk);
    if (state != s) check("wait_state", {29'd0, state}, {29'd0, s});
  endtask

  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check("rsp_arrived", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check("idle_after", {31'd0, busy}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},     {29'd0, state},          0);
    check({tag, "_req_ready"}, {31'd0, bus.req_ready},  1);
    check({tag, "_tx_start"},  {31'd0, bus.tx_start},   0);
    check({tag, "_tx_data"},   {24'd0, bus.tx_data},    0);
    check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid},  0);
    check({tag, "_rsp_data"},  {24'd0, bus.rsp_data},   0);
    check({tag, "_rsp_err"},   {31'd0, bus.rsp_err},    0);
    check({tag, "_busy"},      {31'd0, busy},           0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int tx_base;
    bus.req_valid = 1'b0;
    bus.req_cmd   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;

    // reset at time 0
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;
    @(negedge clk);

    // basic command / reply
    busy_len = 10;
    tx_base  = n_tx;
    send_cmd(8'h31);
    exp_q.push_back({1'b0, 8'h4F});
    wait_state(3'd3, 200);
    repeat (20) @(negedge clk);
    pulse_rx(8'h4F);
    wait_done(200);
    check("basic_tx_count", n_tx - tx_base, 1);

    // a few random command/reply pairs
    for (int k = 0; k < 4; k++) begin
      logic [7:0] c, r;
      c        = 8'($urandom_range(0, 255));
      r        = 8'($urandom_range(0, 255));
      busy_len = $urandom_range(1, 15);
      tx_base  = n_tx;
      send_cmd(c);
      exp_q.push_back({1'b0, r});
      wait_state(3'd3, 200);
      repeat ($urandom_range(0, 40)) @(negedge clk);
      pulse_rx(r);
      wait_done(200);
      check("rand_tx_count", n_tx - tx_base, 1);
    end

    // no reply: timeout in WAIT_RSP on every attempt
    busy_len = 5;
    tx_base  = n_tx;
    send_cmd(8'hC3);
    exp_q.push_back({1'b1, 8'h00});
    wait_done(2000);
    check("rsp_timeout_tx_count", n_tx - tx_base, EXP_ATTEMPTS);

    // transmitter never goes busy: timeout in WAIT_TX
    busy_len = 0;
    tx_base  = n_tx;
    send_cmd(8'h5C);
    exp_q.push_back({1'b1, 8'h00});
    wait_done(2000);
    check("tx_timeout_tx_count", n_tx - tx_base, EXP_ATTEMPTS);

    // reply exactly on the terminal count of WAIT_RSP wins
    busy_len = 4;
    tx_base  = n_tx;
    send_cmd(8'h66);
    exp_q.push_back({1'b0, 8'hA5});
    wait_state(3'd3, 200);
    repeat (TO_CYC - 1) @(negedge clk);
    pulse_rx(8'hA5);
    wait_done(200);
    check("terminal_tx_count", n_tx - tx_base, 1);

    // tx_busy held at SEND, stray bytes in IDLE and WAIT_TX dropped
    busy_len  = 10;
    hold_busy = 1'b1;
    pulse_rx(8'hEE);
    tx_base = n_tx;
    send_cmd(8'h77);
    repeat (30) @(negedge clk);
    check("held_no_tx", n_tx - tx_base, 0);
    check("held_state", {29'd0, state}, 1);
    hold_busy = 1'b0;
    wait_state(3'd2, 20);
    pulse_rx(8'hEE);
    exp_q.push_back({1'b0, 8'h5A});
    wait_state(3'd3, 200);
    repeat (3) @(negedge clk);
    pulse_rx(8'h5A);
    wait_done(200);
    check("held_tx_count", n_tx - tx_base, 1);

    // reset during WAIT_RSP aborts silently
    busy_len = 5;
    send_cmd(8'h12);
    wait_state(3'd3, 200);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b1;
    @(negedge clk);
    pulse_rx(8'h99);
    repeat (5) @(negedge clk);
    check("post_reset_state", {29'd0, state}, 0);
    check("post_reset_busy", {31'd0, busy}, 0);
    check("post_reset_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_err);
    $fatal(1);
  end

endmodule
